iob_axi_sram_resp: RTL and testbench

IOB_AXI_SRAM_RESP -- requirements
Module: iob_axi_sram_resp

---
 rtl/iob_axi_sram_resp_pkg.sv | 15 +
 rtl/iob_ram_sp_be.sv | 27 ++
 rtl/iob_axi_sram_resp.sv | 183 ++++++++++++++++++
 tb/tb_iob_axi_sram_resp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/iob_axi_sram_resp_pkg.sv
// Shared configuration for the AXI SRAM responder: FSM encodings and response codes.
package iob_axi_sram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered (1-cycle) read.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   d_o
);

  // One narrow array per byte lane; the read register holds while en_i is low.
  for (genvar g = 0; g < DATA_W/8; g++) begin : g_lane
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] q;
    always_ff @(posedge clk_i) begin
      if (en_i) begin
        if (we_i[g]) mem[addr_i] <= d_i[g*8 +: 8];
        q <= mem[addr_i];
      end
    end
    assign d_o[g*8 +: 8] = q;
  end

endmodule

// File: rtl/iob_axi_sram_resp.sv
// AXI4 responder over a byte-enabled single-port RAM; one transaction in flight at a time.
module iob_axi_sram_resp
  import iob_axi_sram_resp_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 4,
  parameter int AXI_ADDR_W = 14,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic [1:0]              axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic [1:0]              axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [2:0]              axi_arprot_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam int STRB_W   = AXI_DATA_W/8;
  localparam int BYTE_OFF = $clog2(STRB_W);
  localparam int CNT_W    = AXI_LEN_W + 1;

  state_t                  state, state_nxt;
  logic [AXI_ID_W-1:0]     id_q;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [AXI_LEN_W-1:0]    len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    wlast_err_q;
  logic [CNT_W-1:0]        beat_cnt, iss_cnt;
  logic                    rvalid_q;
  logic                    size_err, beat_last, more_iss, rd_issue, wr_beat, r_hs;
  logic                    ram_en;
  logic [STRB_W-1:0]       ram_we;
  logic [AXI_DATA_W-1:0]   ram_q;
  logic                    unused_sigs;

  assign unused_sigs = ^{axi_awlock_i, axi_awcache_i, axi_awprot_i,
                         axi_arlock_i, axi_arcache_i, axi_arprot_i};

  assign size_err  = size_q > 3'(BYTE_OFF);
  assign beat_last = beat_cnt == CNT_W'(len_q);
  assign more_iss  = iss_cnt != (CNT_W'(len_q) + CNT_W'(1));
  assign r_hs      = rvalid_q & axi_rready_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Handshake readies are gated by reset so nothing is accepted while it is held.
  always_comb begin
    state_nxt     = state;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    rd_issue      = 1'b0;
    wr_beat       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arstn_i && axi_awvalid_i) begin
          axi_awready_o = 1'b1;
          state_nxt     = ST_WDATA;
        end else if (arstn_i && axi_arvalid_i) begin
          axi_arready_o = 1'b1;
          state_nxt     = ST_RDATA;
        end
      end
      ST_WDATA: begin
        axi_wready_o = 1'b1;
        wr_beat      = axi_wvalid_i;
        if (wr_beat && beat_last) state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_nxt = ST_IDLE;
      end
      ST_RDATA: begin
        // Issue the next RAM read whenever the output slot is empty or draining.
        rd_issue = more_iss && (!rvalid_q || axi_rready_i);
        if (r_hs && beat_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      wlast_err_q <= 1'b0;
      beat_cnt    <= '0;
      iss_cnt     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      if (axi_awready_o) begin
        id_q    <= axi_awid_i;
        addr_q  <= axi_awaddr_i;
        len_q   <= axi_awlen_i;
        size_q  <= axi_awsize_i;
        burst_q <= axi_awburst_i;
      end else if (axi_arready_o) begin
        id_q    <= axi_arid_i;
        addr_q  <= axi_araddr_i;
        len_q   <= axi_arlen_i;
        size_q  <= axi_arsize_i;
        burst_q <= axi_arburst_i;
      end else if ((wr_beat || rd_issue) && burst_q != BURST_FIXED) begin
        addr_q <= addr_q + (AXI_ADDR_W'(1) << size_q);
      end
      if (axi_awready_o || axi_arready_o) begin
        wlast_err_q <= 1'b0;
        beat_cnt    <= '0;
        iss_cnt     <= '0;
      end else begin
        if (wr_beat && (axi_wlast_i != beat_last)) wlast_err_q <= 1'b1;
        if (wr_beat || (state == ST_RDATA && r_hs)) beat_cnt <= beat_cnt + CNT_W'(1);
        if (rd_issue) iss_cnt <= iss_cnt + CNT_W'(1);
      end
      if (rd_issue)          rvalid_q <= 1'b1;
      else if (axi_rready_i) rvalid_q <= 1'b0;
    end
  end

  assign ram_en = rd_issue | (wr_beat & ~size_err);
  assign ram_we = (wr_beat && !size_err) ? axi_wstrb_i : '0;

  iob_ram_sp_be #(
    .DATA_W (AXI_DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (addr_q[MEM_ADDR_W+BYTE_OFF-1:BYTE_OFF]),
    .d_i    (axi_wdata_i),
    .d_o    (ram_q)
  );

  assign axi_bid_o   = axi_bvalid_o ? id_q : '0;
  assign axi_bresp_o = (axi_bvalid_o && (wlast_err_q || size_err)) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rvalid_o = rvalid_q;
  assign axi_rid_o    = rvalid_q ? id_q : '0;
  assign axi_rdata_o  = (rvalid_q && !size_err) ? ram_q : '0;
  assign axi_rresp_o  = (rvalid_q && size_err) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rlast_o  = rvalid_q && beat_last;

endmodule

// File: tb/tb_iob_axi_sram_resp.sv
// Directed bench for iob_axi_sram_resp: single/burst/strobe/error/arbitration/alias/reset cases.
module tb_iob_axi_sram_resp;

  logic        clk = 1'b0;
  logic        arstn;
  logic [0:0]  awid, arid, bid, rid;
  logic [13:0] awaddr, araddr;
  logic [3:0]  awlen, arlen, awcache, arcache, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [16];

  always #5 clk = ~clk;

  iob_axi_sram_resp dut (
    .clk_i(clk), .arstn_i(arstn),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
    .axi_awburst_i(awburst), .axi_awlock_i(awlock), .axi_awcache_i(awcache),
    .axi_awprot_i(awprot), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
    .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
    .axi_arburst_i(arburst), .axi_arlock_i(arlock), .axi_arcache_i(arcache),
    .axi_arprot_i(arprot), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a rising edge.
  task automatic aw_send(input logic id, input logic [13:0] a, input logic [3:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("aw_accept_delay", n, 0);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [13:0] a, input logic [3:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_accept_delay", n, 0);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic w_burst(input int n, input logic [3:0] strb, input int bad_last);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1; wdata = exp_q[i]; wstrb = strb;
      wlast = (bad_last >= 0) ? (i == bad_last) : (i == n-1);
      @(negedge clk);
      chk("wready", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait(input logic [1:0] resp, input logic id);
    int n = 0;
    bready = 1'b1;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_delay", n, 0);
    chk("bresp", bresp, resp);
    chk("bid", bid, id);
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic r_collect(input int len, input bit toggle, input logic [1:0] resp, input logic id);
    int beat = 0;
    int cyc = 0;
    bit held = 0;
    logic [31:0] hd;
    logic hl;
    while (beat <= len && cyc < 200) begin
      rready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      if (cyc == 0) chk("r_lat_c0", rvalid, 0);
      if (cyc == 1) chk("r_lat_c1", rvalid, 1);
      if (held) begin
        chk("r_stall_data", rdata, hd);
        chk("r_stall_last", rlast, hl);
      end
      if (rvalid && rready) begin
        chk("rdata", rdata, exp_q[beat]);
        chk("rlast", rlast, beat == len);
        chk("rresp", rresp, resp);
        chk("rid", rid, id);
        beat++; held = 0;
      end else if (rvalid) begin
        held = 1; hd = rdata; hl = rlast;
      end else held = 0;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    chk("r_beat_count", beat, len+1);
  endtask

  initial begin
    logic [14:0] alias_a;
    arstn = 1'b0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    awvalid = 1; arvalid = 1; wvalid = 1; wdata = 0; wstrb = 0; wlast = 0; bready = 1; rready = 1;

    // Reset: everything quiet even with valids driven.
    @(negedge clk); @(negedge clk);
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);     chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);         chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    awvalid = 0; arvalid = 0; wvalid = 0; bready = 0; rready = 0;
    arstn = 1'b1;
    @(posedge clk); #1;

    // Single write then read.
    exp_q[0] = 32'hDEADBEEF;
    aw_send(0, 14'h10, 0, 2, 2'b01); w_burst(1, 4'hF, -1); b_wait(2'b00, 0);
    ar_send(0, 14'h10, 0, 2, 2'b01); r_collect(0, 0, 2'b00, 0);

    // INCR burst of 16, read back with rready toggling.
    for (int i = 0; i < 16; i++) exp_q[i] = i;
    aw_send(0, 14'h40, 15, 2, 2'b01); w_burst(16, 4'hF, -1); b_wait(2'b00, 0);
    ar_send(0, 14'h40, 15, 2, 2'b01); r_collect(15, 1, 2'b00, 0);

    // Byte strobes.
    exp_q[0] = 32'hFFFFFFFF;
    aw_send(0, 14'h80, 0, 2, 2'b01); w_burst(1, 4'hF, -1); b_wait(2'b00, 0);
    exp_q[0] = 32'h00000000;
    aw_send(0, 14'h80, 0, 2, 2'b01); w_burst(1, 4'h5, -1); b_wait(2'b00, 0);
    exp_q[0] = 32'hFF00FF00;
    ar_send(0, 14'h80, 0, 2, 2'b01); r_collect(0, 0, 2'b00, 0);

    // Early wlast on beat 2 of a 4-beat burst.
    for (int i = 0; i < 4; i++) exp_q[i] = 32'h0BAD0000 + i;
    aw_send(0, 14'h200, 3, 2, 2'b01); w_burst(4, 4'hF, 1); b_wait(2'b10, 0);

    // Oversize write: SLVERR and memory untouched.
    exp_q[0] = 32'h0;
    aw_send(0, 14'h10, 0, 3, 2'b01); w_burst(1, 4'hF, -1); b_wait(2'b10, 0);
    exp_q[0] = 32'hDEADBEEF;
    ar_send(0, 14'h10, 0, 2, 2'b01); r_collect(0, 0, 2'b00, 0);

    // Oversize read: two zero beats with SLVERR.
    exp_q[0] = 0; exp_q[1] = 0;
    ar_send(0, 14'h10, 1, 3, 2'b01); r_collect(1, 0, 2'b10, 0);

    // Simultaneous AW/AR: write wins, read accepted right after B; write wraps past top word.
    exp_q[0] = 32'hCAFE0001; exp_q[1] = 32'hCAFE0002;
    alias_a = 15'h4000;
    awid = 1; awaddr = 14'h3FFC; awlen = 1; awsize = 2; awburst = 2'b01;
    arid = 0; araddr = alias_a[13:0]; arlen = 0; arsize = 2; arburst = 2'b01;
    awvalid = 1; arvalid = 1;
    @(negedge clk);
    chk("arb_awready", awready, 1); chk("arb_arready", arready, 0);
    @(posedge clk); #1 awvalid = 0;
    w_burst(2, 4'hF, -1);
    bready = 1;
    @(negedge clk);
    chk("arb_bvalid", bvalid, 1); chk("arb_bid", bid, 1); chk("arb_bresp", bresp, 0);
    chk("arb_ar_held", arready, 0);
    @(posedge clk); #1 bready = 0;
    @(negedge clk);
    chk("arb_ar_next", arready, 1);
    @(posedge clk); #1 arvalid = 0;
    exp_q[0] = 32'hCAFE0002;
    r_collect(0, 0, 2'b00, 0);

    exp_q[0] = 32'hCAFE0001; exp_q[1] = 32'hCAFE0002;
    ar_send(0, 14'h3FFC, 1, 2, 2'b01); r_collect(1, 0, 2'b00, 0);

    // Reset during beat 3 of an 8-beat write over known background.
    for (int i = 0; i < 8; i++) exp_q[i] = 32'hAAAA0000 + i;
    aw_send(0, 14'h100, 7, 2, 2'b01); w_burst(8, 4'hF, -1); b_wait(2'b00, 0);
    for (int i = 0; i < 8; i++) exp_q[i] = 32'h55550000 + i;
    aw_send(0, 14'h100, 7, 2, 2'b01); w_burst(3, 4'hF, 7);
    wvalid = 1; wdata = exp_q[3]; wstrb = 4'hF; wlast = 0; awvalid = 1;
    #2 arstn = 1'b0;
    @(negedge clk);
    chk("mrst_wready", wready, 0);   chk("mrst_awready", awready, 0);
    chk("mrst_bvalid", bvalid, 0);   chk("mrst_rvalid", rvalid, 0);
    chk("mrst_rdata", rdata, 0);
    @(posedge clk); #1;
    awvalid = 0; arstn = 1'b1;
    wdata = exp_q[4];
    @(negedge clk);
    chk("mrst_idle_wready", wready, 0);
    @(posedge clk); #1 wdata = exp_q[5];
    @(posedge clk); #1 wvalid = 0;
    for (int i = 0; i < 8; i++) exp_q[i] = (i < 3) ? 32'h55550000 + i : 32'hAAAA0000 + i;
    ar_send(0, 14'h100, 7, 2, 2'b01); r_collect(7, 0, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
